imem_loader: RTL and testbench

Boot-time sequencer for the instruction memory. Drains a program of `prog_len` 32-bit instructions from the instruction FIFO and writes them into instruction memory at consecutive word-aligned byte addresses (0, 4, 8, …). Holds the processor in run-disable until the load completes, then releases it. Sits between the FIFO read side and the instruction memory write port (`data_in`/`dir`/`we`).

---
 rtl/imem_pkg.sv | 6 +
 rtl/imem_loader.sv | 98 +++++++++
 tb/tb_imem_loader.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory boot loader.
package imem_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, DONE} loader_state_t;
  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS  = 64;
endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: pops prog_len words from the instruction FIFO into
// instruction memory at byte addresses 0,4,8,... then releases the CPU.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [6:0]            prog_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  mem_we,
  output logic [BYTE_WIDTH-1:0] mem_dir,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  busy,
  output logic                  load_done,
  output logic                  len_err,
  output logic                  cpu_run
);

  localparam logic [6:0] MAX_W = 7'(MEM_DEPTH / WORD_BYTES);

  loader_state_t         state, state_n;
  logic [BYTE_WIDTH-1:0] addr;
  logic [6:0]            wcnt, len;
  logic                  load, err_set, err_clr;

  always_comb begin
    state_n = state;
    load    = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (prog_len == 7'd0) begin
            state_n = DONE;
            err_clr = 1'b1;
          end else if (prog_len > MAX_W) begin
            state_n = IDLE;
            err_set = 1'b1;
          end else begin
            state_n = FETCH;
            load    = 1'b1;
          end
        end
      end
      FETCH:   if (!fifo_empty) state_n = CAPTURE;
      CAPTURE: state_n = WRITE;
      WRITE:   state_n = (wcnt + 7'd1 == len) ? DONE : FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      wcnt     <= '0;
      len      <= '0;
      len_err  <= 1'b0;
      mem_we   <= 1'b0;
      mem_dir  <= '0;
      mem_data <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        len  <= prog_len;
        wcnt <= '0;
        addr <= '0;
      end
      if (err_set) len_err <= 1'b1;
      else if (load || err_clr) len_err <= 1'b0;
      // FIFO data arrives the cycle after the pop, so it is captured in CAPTURE.
      if (state == CAPTURE) begin
        mem_data <= fifo_dout;
        mem_dir  <= addr;
        mem_we   <= 1'b1;
      end
      if (state == WRITE) begin
        mem_we <= 1'b0;
        addr   <= addr + BYTE_WIDTH'(WORD_BYTES);
        wcnt   <= wcnt + 7'd1;
      end
    end
  end

  assign fifo_rd_en = (state == FETCH) && !fifo_empty;
  assign busy       = (state == FETCH) || (state == CAPTURE) || (state == WRITE);
  assign load_done  = (state == DONE);
  assign cpu_run    = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of lengths, corner sequences, random loads.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n, start, fifo_empty;
  logic [6:0]  prog_len;
  logic        fifo_rd_en, mem_we, busy, load_done, len_err, cpu_run;
  logic [31:0] fifo_dout = '0;
  logic [7:0]  mem_dir;
  logic [31:0] mem_data;

  imem_loader #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .mem_we(mem_we), .mem_dir(mem_dir), .mem_data(mem_data), .busy(busy),
    .load_done(load_done), .len_err(len_err), .cpu_run(cpu_run)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // FIFO model: pop on rd_en, data visible the following cycle; optional stall window.
  logic [31:0] fifo_q[$];
  int          pops = 0;
  int          stall_at = -1;
  int          stall_len = 0;
  bit          stalled;
  initial fifo_empty = 1'b1;
  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_dout <= fifo_q.pop_front();
      pops++;
    end
    #1;
    stalled = (pops == stall_at) && (stall_len > 0);
    if (stalled) stall_len--;
    fifo_empty = (fifo_q.size() == 0) || stalled;
  end

  // Write/pop monitor.
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  int          rd_cnt = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_dir);
      wr_data.push_back(mem_data);
    end
    if (fifo_rd_en) rd_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  logic [31:0] next_words[$];

  // Reference: N accepted words land at 4*i with the i-th FIFO word, one pop each,
  // load_done at cycle 3N+1 (cycle 0 = start cycle) when the FIFO never stalls.
  task automatic do_load(input logic [6:0] len, input bit exp_err, input int exp_n,
                         input int exp_lat, input int st_at, input int st_len,
                         input bit dbl);
    logic [31:0] exp_q[$];
    int cyc;
    exp_q.delete();
    for (int i = 0; i < exp_n; i++) begin
      logic [31:0] w;
      w = (next_words.size() > 0) ? next_words.pop_front() : $urandom;
      exp_q.push_back(w);
      fifo_q.push_back(w);
    end
    @(posedge clk);
    #2;
    wr_addr.delete(); wr_data.delete(); rd_cnt = 0; pops = 0;
    stall_at = st_at; stall_len = st_len;
    start = 1'b1; prog_len = len;
    @(posedge clk);
    #2;
    cyc = 0;
    if (dbl) begin
      prog_len = len + 7'd3;
      @(negedge clk);
      cyc = 1;
      chk("restart_cpu_run_drop", cpu_run, 0);
      chk("restart_busy", busy, 1);
      @(posedge clk);
      #2;
    end
    start = 1'b0;
    if (exp_err) begin
      repeat (4) @(negedge clk);
      chk("err_len_err", len_err, 1);
      chk("err_cpu_run", cpu_run, 0);
      chk("err_busy", busy, 0);
      chk("err_rd_cnt", rd_cnt, 0);
      chk("err_writes", wr_addr.size(), 0);
      return;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (load_done) break;
      if (cyc > 1500) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    if (exp_lat >= 0) chk("latency", cyc, exp_lat);
    chk("cpu_run", cpu_run, 1);
    chk("busy_at_done", busy, 0);
    chk("len_err_clear", len_err, 0);
    chk("pop_count", rd_cnt, exp_n);
    chk("write_count", wr_addr.size(), exp_n);
    for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), {24'd0, wr_addr[i]}, 32'(4 * i));
      chk($sformatf("wr_data[%0d]", i), wr_data[i], exp_q[i]);
    end
  endtask

  typedef struct {
    logic [6:0] len;
    bit         exp_err;
    int         exp_n;
    int         exp_lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{7'd4,   1'b0, 4,  13};
    tbl[1] = '{7'd0,   1'b0, 0,  1};
    tbl[2] = '{7'd64,  1'b0, 64, 193};
    tbl[3] = '{7'd65,  1'b1, 0,  -1};
    tbl[4] = '{7'd1,   1'b0, 1,  4};
    tbl[5] = '{7'd127, 1'b1, 0,  -1};
    tbl[6] = '{7'd2,   1'b0, 2,  7};

    rst_n = 1'b0; start = 1'b0; prog_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_mem_dir", mem_dir, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Pre-filled FIFO, known program.
    next_words = '{32'h00000013, 32'h00100093, 32'h00208113, 32'hFFDFF06F};
    foreach (tbl[i]) do_load(tbl[i].len, tbl[i].exp_err, tbl[i].exp_n, tbl[i].exp_lat, -1, 0, 1'b0);

    // Stall before the 2nd word: 3 of the 5 empty cycles fall in FETCH.
    do_load(7'd3, 1'b0, 3, 13, 1, 5, 1'b0);

    // Restart from DONE, with start still high (and prog_len changed) during FETCH.
    do_load(7'd2, 1'b0, 2, 7, -1, 0, 1'b1);

    // Reset in the middle of the 2nd write.
    for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
    @(posedge clk);
    #2 wr_addr.delete(); wr_data.delete(); start = 1'b1; prog_len = 7'd4;
    @(posedge clk);
    #2 start = 1'b0;
    for (int c = 0; c < 100 && wr_addr.size() < 2; c++) @(negedge clk);
    chk("midrst_reached_2nd_write", wr_addr.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", mem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_dir", mem_dir, 0);
    chk("midrst_mem_data", mem_data, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_cpu_run", cpu_run, 0);
    fifo_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_load(7'd2, 1'b0, 2, 7, -1, 0, 1'b0);

    // Random loads, some with a stall window (latency then unchecked).
    for (int r = 0; r < 8; r++) begin
      int n, sa, sl;
      n  = $urandom_range(1, 20);
      sl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      sa = (sl > 0) ? $urandom_range(0, n - 1) : -1;
      do_load(7'(n), 1'b0, n, (sl > 0) ? -1 : 3 * n + 1, sa, sl, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
